// File: rtl/csr_excp_ctrl_pkg.sv
// Shared definitions for the commit-side CSR / exception controller:
// CSR indices, exception codes, request opcodes and the FSM encoding.
package csr_excp_ctrl_pkg;

  localparam int EXCP_W_DEF = 5;

  // Bit positions inside in_excp_vec
  localparam int EXCP_BIT_ADEF = 0;
  localparam int EXCP_BIT_INE  = 1;
  localparam int EXCP_BIT_SYS  = 2;
  localparam int EXCP_BIT_BRK  = 3;
  localparam int EXCP_BIT_ALE  = 4;

  // Exception codes reported in ESTAT.Ecode
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_INE  = 6'h0D;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_ALE  = 6'h09;

  // CSR register indices
  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;

  typedef enum logic [2:0] {
    OP_NONE    = 3'd0,
    OP_CSRRD   = 3'd1,
    OP_CSRWR   = 3'd2,
    OP_CSRXCHG = 3'd3,
    OP_ERTN    = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CSR_RD = 3'd1,
    ST_CSR_WR = 3'd2,
    ST_EXCP   = 3'd3,
    ST_ERTN   = 3'd4
  } state_e;

  typedef struct packed {
    logic [5:0] ecode;
    logic [2:0] esubcode;
  } excp_code_t;

  // Ecode for a given exception-vector bit position
  function automatic logic [5:0] ecode_of(input int idx);
    logic [5:0] code;
    case (idx)
      EXCP_BIT_ADEF: code = ECODE_ADEF;
      EXCP_BIT_INE:  code = ECODE_INE;
      EXCP_BIT_SYS:  code = ECODE_SYS;
      EXCP_BIT_BRK:  code = ECODE_BRK;
      EXCP_BIT_ALE:  code = ECODE_ALE;
      default:       code = 6'h00;
    endcase
    return code;
  endfunction

  function automatic logic is_csr_op(input logic [2:0] op);
    return (op == OP_CSRRD) || (op == OP_CSRWR) || (op == OP_CSRXCHG);
  endfunction

endpackage

// File: rtl/csr_excp_ctrl_prio.sv
// Combinational priority encoder: exception vector -> {ecode, esubcode}.
// Lower bit index has higher priority (ADEF > INE > SYS > BRK > ALE).
module csr_excp_prio
  import csr_excp_ctrl_pkg::*;
#(
  parameter int EXCP_W = EXCP_W_DEF
) (
  input  logic [EXCP_W-1:0] excp_vec_i,
  output excp_code_t        code_o
);

  // Scan from lowest priority upward so the highest-priority set bit wins
  always_comb begin
    code_o.ecode    = 6'h00;
    code_o.esubcode = 3'd0;
    for (int i = EXCP_W - 1; i >= 0; i--) begin
      if (excp_vec_i[i]) begin
        code_o.ecode = ecode_of(i);
      end
    end
  end

endmodule

// File: rtl/csr_excp_ctrl.sv
// Commit-side initiator for the CSR register file. Sequences csrrd /
// csrwr / csrxchg, exception entry and ertn, returns the old CSR value to
// the GPR write port and a redirect PC to fetch.
// Optional feature: define CSR_EXCP_CNT_EN to add the excp_cnt output.
//
// Handshake: a request transfers on a rising clock edge where
// in_valid && in_ready; in_ready is high only in IDLE, all request fields
// are captured at that edge and the upstream may change them afterwards.
module csr_excp_ctrl
  import csr_excp_ctrl_pkg::*;
#(
  parameter int EXCP_W = EXCP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [31:0]       in_pc,
  input  logic [13:0]       in_csr_num,
  input  logic [31:0]       in_rd_val,
  input  logic [31:0]       in_rj_val,
  input  logic [4:0]        in_rd,
  input  logic [EXCP_W-1:0] in_excp_vec,
  output logic              csr_we,
  output logic [13:0]       csr_num,
  output logic [31:0]       csr_wdata,
  input  logic [31:0]       csr_rdata,
  output logic              excp_flush,
  output logic              ertn_flush,
  output logic [5:0]        ecode,
  output logic [2:0]        esubcode,
  output logic [31:0]       epc,
  input  logic [31:0]       era,
  input  logic [31:0]       eentry,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              flush_valid,
  output logic [31:0]       flush_pc,
`ifdef CSR_EXCP_CNT_EN
  output logic [31:0]       excp_cnt,
`endif
  output logic [2:0]        dbg_state
);

  state_e     state_q, state_d;
  op_e        op_q;
  logic [31:0] pc_q;
  logic [13:0] num_q;
  logic [31:0] rd_val_q;
  logic [31:0] rj_val_q;
  logic [4:0]  rd_q;
  logic [31:0] old_q;
  excp_code_t  code_q;
  excp_code_t  prio_code;
  logic        accept;
  logic        has_excp;

  assign accept   = in_valid && in_ready;
  assign has_excp = |in_excp_vec;

  csr_excp_prio #(
    .EXCP_W (EXCP_W)
  ) u_prio (
    .excp_vec_i (in_excp_vec),
    .code_o     (prio_code)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: exceptions override whatever op came with them
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (has_excp) begin
            state_d = ST_EXCP;
          end else if (in_op == OP_ERTN) begin
            state_d = ST_ERTN;
          end else if (is_csr_op(in_op)) begin
            state_d = ST_CSR_RD;
          end
        end
      end
      ST_CSR_RD: state_d = ST_CSR_WR;
      ST_CSR_WR: state_d = ST_IDLE;
      ST_EXCP:   state_d = ST_IDLE;
      ST_ERTN:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request latch; csr_num / ecode only move for the request that uses them
  // so they keep their last meaningful value while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= OP_NONE;
      pc_q     <= 32'd0;
      num_q    <= 14'd0;
      rd_val_q <= 32'd0;
      rj_val_q <= 32'd0;
      rd_q     <= 5'd0;
      code_q   <= '0;
      old_q    <= 32'd0;
    end else begin
      if (accept) begin
        op_q     <= op_e'(in_op);
        pc_q     <= in_pc;
        rd_val_q <= in_rd_val;
        rj_val_q <= in_rj_val;
        rd_q     <= in_rd;
        if (has_excp) begin
          code_q <= prio_code;
        end else if (is_csr_op(in_op)) begin
          num_q <= in_csr_num;
        end
      end
      if (state_q == ST_CSR_RD) begin
        old_q <= csr_rdata;
      end
    end
  end

  // FSM outputs: every strobe is a single-cycle pulse tied to one state
  always_comb begin
    in_ready    = 1'b0;
    csr_we      = 1'b0;
    csr_wdata   = 32'd0;
    excp_flush  = 1'b0;
    ertn_flush  = 1'b0;
    epc         = 32'd0;
    wb_valid    = 1'b0;
    wb_rd       = 5'd0;
    wb_data     = 32'd0;
    flush_valid = 1'b0;
    flush_pc    = 32'd0;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_CSR_WR: begin
        wb_valid = 1'b1;
        wb_rd    = rd_q;
        wb_data  = old_q;
        if (op_q == OP_CSRWR) begin
          csr_we    = 1'b1;
          csr_wdata = rd_val_q;
        end else if (op_q == OP_CSRXCHG) begin
          csr_we    = 1'b1;
          csr_wdata = (old_q & ~rj_val_q) | (rd_val_q & rj_val_q);
        end
      end
      ST_EXCP: begin
        excp_flush  = 1'b1;
        epc         = pc_q;
        flush_valid = 1'b1;
        flush_pc    = eentry;
      end
      ST_ERTN: begin
        ertn_flush  = 1'b1;
        flush_valid = 1'b1;
        flush_pc    = era;
      end
      default: ;
    endcase
  end

  assign csr_num   = num_q;
  assign ecode     = code_q.ecode;
  assign esubcode  = code_q.esubcode;
  assign dbg_state = state_q;

`ifdef CSR_EXCP_CNT_EN
  logic [31:0] excp_cnt_q;

  // Exception commit counter, wraps naturally at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      excp_cnt_q <= 32'd0;
    end else if (excp_flush) begin
      excp_cnt_q <= excp_cnt_q + 32'd1;
    end
  end

  assign excp_cnt = excp_cnt_q;
`endif

endmodule

// File: tb/tb_csr_excp_ctrl.sv
// Bench for csr_excp_ctrl: directed cases plus randomized requests checked
// against a transaction-level model of the CSR file and exception rules.
module tb_csr_excp_ctrl;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_pc;
  logic [13:0] in_csr_num;
  logic [31:0] in_rd_val;
  logic [31:0] in_rj_val;
  logic [4:0]  in_rd;
  logic [4:0]  in_excp_vec;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        excp_flush;
  logic        ertn_flush;
  logic [5:0]  ecode;
  logic [2:0]  esubcode;
  logic [31:0] epc;
  logic [31:0] era;
  logic [31:0] eentry;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush_valid;
  logic [31:0] flush_pc;
  logic [2:0]  dbg_state;
`ifdef CSR_EXCP_CNT_EN
  logic [31:0] excp_cnt;
`endif

  csr_excp_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_pc       (in_pc),
    .in_csr_num  (in_csr_num),
    .in_rd_val   (in_rd_val),
    .in_rj_val   (in_rj_val),
    .in_rd       (in_rd),
    .in_excp_vec (in_excp_vec),
    .csr_we      (csr_we),
    .csr_num     (csr_num),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .excp_flush  (excp_flush),
    .ertn_flush  (ertn_flush),
    .ecode       (ecode),
    .esubcode    (esubcode),
    .epc         (epc),
    .era         (era),
    .eentry      (eentry),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .flush_valid (flush_valid),
    .flush_pc    (flush_pc),
`ifdef CSR_EXCP_CNT_EN
    .excp_cnt    (excp_cnt),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- bench CSR file (read by DUT, written by csr_we) -----
  logic [31:0] csr_mem [16];
  logic        pre_en;
  logic [3:0]  pre_idx;
  logic [31:0] pre_val;

  assign csr_rdata = csr_mem[csr_num[3:0]];

  always @(posedge clk) begin
    if (pre_en) csr_mem[pre_idx] <= pre_val;
    else if (csr_we) csr_mem[csr_num[3:0]] <= csr_wdata;
  end

  // ---------------- reference model state ----------------
  logic [31:0] ref_mem [16];
  logic [13:0] last_num;
  logic [5:0]  last_ecode;
  logic [31:0] exp_cnt;
  logic [5:0]  code_tab [5];

  // scoreboard queues: {rd, data}, {num, wdata}, {is_excp, ecode, epc, target}
  logic [36:0] exp_wb_q[$];
  logic [45:0] exp_we_q[$];
  logic [70:0] exp_fl_q[$];

  int checks;
  int failures;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  // Architectural priority: first set bit in ADEF, INE, SYS, BRK, ALE order
  function automatic logic [5:0] ref_ecode(input logic [4:0] vec);
    for (int i = 0; i < 5; i++) if (vec[i]) return code_tab[i];
    return 6'h00;
  endfunction

  // ---------------- monitor ----------------
  logic [36:0] m_wb;
  logic [45:0] m_we;
  logic [70:0] m_fl;

  always @(negedge clk) begin
    if (!reset) begin
      check("pulse_mutex", {31'd0, ($countones({excp_flush, ertn_flush, csr_we}) <= 1)}, 32'd1);
      if (wb_valid) begin
        if (exp_wb_q.size() == 0) check("wb_unexpected", 32'd1, 32'd0);
        else begin
          m_wb = exp_wb_q.pop_front();
          check("wb_rd", {27'd0, wb_rd}, {27'd0, m_wb[36:32]});
          check("wb_data", wb_data, m_wb[31:0]);
        end
      end
      if (csr_we) begin
        if (exp_we_q.size() == 0) check("we_unexpected", 32'd1, 32'd0);
        else begin
          m_we = exp_we_q.pop_front();
          check("we_num", {18'd0, csr_num}, {18'd0, m_we[45:32]});
          check("we_wdata", csr_wdata, m_we[31:0]);
        end
      end
      if (flush_valid || excp_flush || ertn_flush) begin
        if (exp_fl_q.size() == 0) check("flush_unexpected", 32'd1, 32'd0);
        else begin
          m_fl = exp_fl_q.pop_front();
          check("flush_valid", {31'd0, flush_valid}, 32'd1);
          check("excp_flush", {31'd0, excp_flush}, {31'd0, m_fl[70]});
          check("ertn_flush", {31'd0, ertn_flush}, {31'd0, !m_fl[70]});
          check("flush_pc", flush_pc, m_fl[31:0]);
          if (m_fl[70]) begin
            check("ecode", {26'd0, ecode}, {26'd0, m_fl[69:64]});
            check("esubcode", {29'd0, esubcode}, 32'd0);
            check("epc", epc, m_fl[63:32]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_csr(input logic [3:0] idx, input logic [31:0] val);
    @(posedge clk); #1;
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    ref_mem[idx] = val;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic do_req(input logic [2:0] op, input logic [31:0] pc, input logic [13:0] num,
                        input logic [31:0] rdv, input logic [31:0] rjv, input logic [4:0] rd,
                        input logic [4:0] vec, input logic [31:0] era_v, input logic [31:0] eentry_v);
    logic [31:0] old_v;
    logic [31:0] new_v;
    logic [5:0]  code;
    int          lat;
    int          exp_lat;
    @(posedge clk); #1;
    era = era_v; eentry = eentry_v;
    in_valid = 1'b1; in_op = op; in_pc = pc; in_csr_num = num;
    in_rd_val = rdv; in_rj_val = rjv; in_rd = rd; in_excp_vec = vec;
    @(negedge clk);
    check("ready_idle", {31'd0, in_ready}, 32'd1);
    check("csr_num_hold", {18'd0, csr_num}, {18'd0, last_num});
    check("ecode_hold", {26'd0, ecode}, {26'd0, last_ecode});
    if (vec != 5'd0) begin
      code = ref_ecode(vec);
      exp_fl_q.push_back({1'b1, code, pc, eentry_v});
      last_ecode = code;
      exp_cnt = exp_cnt + 32'd1;
      exp_lat = 2;
    end else if (op == 3'd4) begin
      exp_fl_q.push_back({1'b0, 6'd0, 32'd0, era_v});
      exp_lat = 2;
    end else if (op >= 3'd1 && op <= 3'd3) begin
      old_v = ref_mem[num[3:0]];
      exp_wb_q.push_back({rd, old_v});
      if (op != 3'd1) begin
        new_v = (op == 3'd2) ? rdv : ((old_v & ~rjv) | (rdv & rjv));
        exp_we_q.push_back({num, new_v});
        ref_mem[num[3:0]] = new_v;
      end
      last_num = num;
      exp_lat = 3;
    end else begin
      exp_lat = 1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = 3'($urandom_range(0, 7)); in_pc = $urandom;
    in_csr_num = 14'($urandom); in_rd_val = $urandom; in_rj_val = $urandom;
    in_rd = 5'($urandom); in_excp_vec = 5'($urandom);
    lat = 1;
    while (lat <= 8) begin
      @(negedge clk);
      if (in_ready) break;
      lat++;
    end
    check("latency", lat, exp_lat);
    check("wb_pending", exp_wb_q.size(), 32'd0);
    check("we_pending", exp_we_q.size(), 32'd0);
    check("flush_pending", exp_fl_q.size(), 32'd0);
`ifdef CSR_EXCP_CNT_EN
    check("excp_cnt", excp_cnt, exp_cnt);
`endif
    exp_wb_q.delete(); exp_we_q.delete(); exp_fl_q.delete();
  endtask

  task automatic model_reset();
    last_num = 14'd0; last_ecode = 6'd0; exp_cnt = 32'd0;
    exp_wb_q.delete(); exp_we_q.delete(); exp_fl_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [4:0] rvec;
    checks = 0; failures = 0;
    code_tab[0] = 6'h08; code_tab[1] = 6'h0D; code_tab[2] = 6'h0B;
    code_tab[3] = 6'h0C; code_tab[4] = 6'h09;
    reset = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_pc = 32'd0; in_csr_num = 14'd0;
    in_rd_val = 32'd0; in_rj_val = 32'd0; in_rd = 5'd0; in_excp_vec = 5'd0;
    era = 32'd0; eentry = 32'd0; pre_en = 1'b0; pre_idx = 4'd0; pre_val = 32'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_csr_we", {31'd0, csr_we}, 32'd0);
    check("rst_excp_flush", {31'd0, excp_flush}, 32'd0);
    check("rst_ertn_flush", {31'd0, ertn_flush}, 32'd0);
    check("rst_flush_valid", {31'd0, flush_valid}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_csr_num", {18'd0, csr_num}, 32'd0);
    check("rst_ecode", {26'd0, ecode}, 32'd0);
    check("rst_epc", epc, 32'd0);
    check("rst_flush_pc", flush_pc, 32'd0);
`ifdef CSR_EXCP_CNT_EN
    check("rst_excp_cnt", excp_cnt, 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) set_csr(4'(i), $urandom);

    // 1: CSRRD of SAVE0
    set_csr(4'h0, 32'h12345678);
    do_req(3'd1, 32'h1C000000, 14'h030, $urandom, $urandom, 5'd3, 5'd0, $urandom, $urandom);
    // 2: CSRXCHG with mask
    set_csr(4'h1, 32'hFFFF0000);
    do_req(3'd3, 32'h1C000004, 14'h031, 32'h0000ABCD, 32'h00FF00FF, 5'd7, 5'd0, $urandom, $urandom);
    check("xchg_result", ref_mem[1], 32'hFF0000CD);
    check("xchg_mem", csr_mem[1], 32'hFF0000CD);
    // 3: SYS+BRK -> SYS
    do_req(3'd1, 32'h1C000040, 14'h032, $urandom, $urandom, 5'd4, 5'b01100, $urandom, 32'h1C008000);
    // 4: CSRWR carrying INE
    do_req(3'd2, 32'h1C000044, 14'h033, $urandom, $urandom, 5'd5, 5'b00010, $urandom, $urandom);
    // 5: ERTN
    do_req(3'd4, 32'h1C000048, 14'h000, $urandom, $urandom, 5'd0, 5'd0, 32'h1C000100, $urandom);
    // NONE: accepted, nothing happens
    do_req(3'd0, 32'h1C00004C, 14'h035, $urandom, $urandom, 5'd1, 5'd0, $urandom, $urandom);

    // 6: reset while in CSR_RD aborts the write
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 3'd2; in_csr_num = 14'h031; in_rd_val = 32'hDEADBEEF;
    in_rj_val = 32'd0; in_rd = 5'd9; in_excp_vec = 5'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("abort_no_we_rd", {31'd0, csr_we}, 32'd0);
    #1 reset = 1'b1;
    #1;
    check("abort_ready", {31'd0, in_ready}, 32'd1);
    check("abort_we", {31'd0, csr_we}, 32'd0);
    check("abort_wb", {31'd0, wb_valid}, 32'd0);
    model_reset();
    @(negedge clk);
    check("abort_we_hold", {31'd0, csr_we}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_mem", csr_mem[1], ref_mem[1]);
    check("abort_idle", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++)
      do_req(3'd0, $urandom, 14'($urandom), $urandom, $urandom, 5'($urandom), 5'(1 << i), $urandom, $urandom);
`ifdef CSR_EXCP_CNT_EN
    check("excp_cnt_three", excp_cnt, 32'd3);
`endif

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      rvec = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      do_req(3'($urandom_range(0, 4)), $urandom, 14'($urandom), $urandom, $urandom,
             5'($urandom), rvec, $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
